// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DMEM_DEPTH = 32'(1) << ADDR_W;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_e;

  // One in-flight response: who it belongs to and how to shape its payload.
  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    write;
    logic    err;
  } resp_pipe_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority holder.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  prio_e prio_q;

  // Contention goes to the priority holder; a lone requester always wins.
  always_comb begin
    gnt_o = 2'b00;
    if (!reset) begin
      if (valid_i == 2'b11) begin
        gnt_o = (prio_q == PRIO0) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = valid_i;
      end
    end
  end

  // Any grant hands priority to the other side; an idle cycle keeps it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= PRIO0;
    end else if (gnt_o[0]) begin
      prio_q <= PRIO1;
    end else if (gnt_o[1]) begin
      prio_q <= PRIO0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (r0) and the host loader (r1);
// one request per cycle, response exactly one cycle after acceptance.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = dmem_pkg::ADDR_W
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic        r0_req_write,
  input  logic [31:0] r0_req_addr,
  input  logic [31:0] r0_req_wdata,
  output logic        r0_resp_valid,
  output logic [31:0] r0_resp_data,
  output logic        r0_resp_err,

  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic        r1_req_write,
  input  logic [31:0] r1_req_addr,
  input  logic [31:0] r1_req_wdata,
  output logic        r1_resp_valid,
  output logic [31:0] r1_resp_data,
  output logic        r1_resp_err,

  output logic [31:0] mem_addr,
  output logic        mem_should_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  import dmem_pkg::*;

  logic [1:0]  gnt;
  logic        any_gnt;
  logic        in_range;
  logic        access;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  resp_pipe_t  resp_d;
  resp_pipe_t  resp_q;
  logic        hit_core;
  logic        hit_host;
  logic        load_ok;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid_i ({r1_req_valid, r0_req_valid}),
    .gnt_o   (gnt)
  );

  assign r0_req_ready = gnt[0];
  assign r1_req_ready = gnt[1];

  // Steer the winning request onto the shared memory port.
  always_comb begin
    sel_write = r0_req_write;
    sel_addr  = r0_req_addr;
    sel_wdata = r0_req_wdata;
    if (gnt[1]) begin
      sel_write = r1_req_write;
      sel_addr  = r1_req_addr;
      sel_wdata = r1_req_wdata;
    end
  end

  assign any_gnt  = |gnt;
  assign in_range = (sel_addr >> ADDR_W) == 32'd0;
  assign access   = any_gnt & in_range;

  // Out-of-range requests never touch the memory port.
  assign mem_addr         = access ? sel_addr  : 32'd0;
  assign mem_should_write = access & sel_write;
  assign mem_write_data   = access ? sel_wdata : 32'd0;

  always_comb begin
    resp_d       = '0;
    resp_d.valid = any_gnt;
    resp_d.id    = gnt[1] ? REQ_HOST : REQ_CORE;
    resp_d.write = sel_write;
    resp_d.err   = ~in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Read data arrives from the memory's posedge sample, so it is muxed live.
  assign hit_core = resp_q.valid && (resp_q.id == REQ_CORE);
  assign hit_host = resp_q.valid && (resp_q.id == REQ_HOST);
  assign load_ok  = ~resp_q.write & ~resp_q.err;

  assign r0_resp_valid = hit_core;
  assign r0_resp_err   = hit_core & resp_q.err;
  assign r0_resp_data  = (hit_core & load_ok) ? mem_read_data : 32'd0;

  assign r1_resp_valid = hit_host;
  assign r1_resp_err   = hit_host & resp_q.err;
  assign r1_resp_data  = (hit_host & load_ok) ? mem_read_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model
// and a small posedge-read / negedge-write memory.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req_valid, r0_req_ready, r0_req_write;
  logic [31:0] r0_req_addr, r0_req_wdata, r0_resp_data;
  logic        r0_resp_valid, r0_resp_err;
  logic        r1_req_valid, r1_req_ready, r1_req_write;
  logic [31:0] r1_req_addr, r1_req_wdata, r1_resp_data;
  logic        r1_resp_valid, r1_resp_err;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_should_write;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          favour  = 0;
  bit          pend_v  = 0;
  int          pend_id = 0;
  bit          pend_err = 0;
  logic [31:0] pend_data = '0;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .r0_req_valid     (r0_req_valid),
    .r0_req_ready     (r0_req_ready),
    .r0_req_write     (r0_req_write),
    .r0_req_addr      (r0_req_addr),
    .r0_req_wdata     (r0_req_wdata),
    .r0_resp_valid    (r0_resp_valid),
    .r0_resp_data     (r0_resp_data),
    .r0_resp_err      (r0_resp_err),
    .r1_req_valid     (r1_req_valid),
    .r1_req_ready     (r1_req_ready),
    .r1_req_write     (r1_req_write),
    .r1_req_addr      (r1_req_addr),
    .r1_req_wdata     (r1_req_wdata),
    .r1_resp_valid    (r1_resp_valid),
    .r1_resp_data     (r1_resp_data),
    .r1_resp_err      (r1_resp_err),
    .mem_addr         (mem_addr),
    .mem_should_write (mem_should_write),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_should_write) mem[mem_addr[AW-1:0]] <= mem_write_data;
  end

  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr[AW-1:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the model: expected response from last cycle's grant, then
  // arbitration and memory-port expectations for the requests on the inputs now.
  task automatic model_cycle();
    int          g;
    logic [31:0] a, d;
    logic        w;
    bit          inr;
    if (reset) begin
      chk("rst_r0_ready", 32'(r0_req_ready), 32'd0);
      chk("rst_r1_ready", 32'(r1_req_ready), 32'd0);
      chk("rst_r0_resp_valid", 32'(r0_resp_valid), 32'd0);
      chk("rst_r1_resp_valid", 32'(r1_resp_valid), 32'd0);
      chk("rst_r0_resp_err", 32'(r0_resp_err), 32'd0);
      chk("rst_r1_resp_err", 32'(r1_resp_err), 32'd0);
      chk("rst_r0_resp_data", r0_resp_data, 32'd0);
      chk("rst_r1_resp_data", r1_resp_data, 32'd0);
      favour = 0;
      pend_v = 0;
      return;
    end
    chk("r0_resp_valid", 32'(r0_resp_valid), 32'(pend_v && pend_id == 0));
    chk("r1_resp_valid", 32'(r1_resp_valid), 32'(pend_v && pend_id == 1));
    chk("r0_resp_err", 32'(r0_resp_err), 32'(pend_v && pend_id == 0 && pend_err));
    chk("r1_resp_err", 32'(r1_resp_err), 32'(pend_v && pend_id == 1 && pend_err));
    chk("r0_resp_data", r0_resp_data, (pend_v && pend_id == 0) ? pend_data : 32'd0);
    chk("r1_resp_data", r1_resp_data, (pend_v && pend_id == 1) ? pend_data : 32'd0);

    g = -1;
    if (r0_req_valid && r1_req_valid) g = favour;
    else if (r0_req_valid) g = 0;
    else if (r1_req_valid) g = 1;
    chk("r0_req_ready", 32'(r0_req_ready), 32'(g == 0));
    chk("r1_req_ready", 32'(r1_req_ready), 32'(g == 1));

    if (g < 0) begin
      chk("idle_mem_should_write", 32'(mem_should_write), 32'd0);
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("idle_mem_write_data", mem_write_data, 32'd0);
      pend_v = 0;
      return;
    end
    favour = 1 - g;
    a   = (g == 0) ? r0_req_addr  : r1_req_addr;
    d   = (g == 0) ? r0_req_wdata : r1_req_wdata;
    w   = (g == 0) ? r0_req_write : r1_req_write;
    inr = a < DEPTH;
    chk("mem_should_write", 32'(mem_should_write), 32'(inr && w));
    if (inr) begin
      chk("mem_addr", mem_addr, a);
      chk("mem_write_data", mem_write_data, d);
    end
    pend_v    = 1;
    pend_id   = g;
    pend_err  = !inr;
    pend_data = (inr && !w) ? ref_mem[a[AW-1:0]] : 32'd0;
    if (inr && w) ref_mem[a[AW-1:0]] = d;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      model_cycle();
    end
  end

  task automatic drive(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    r0_req_valid = v0; r0_req_write = w0; r0_req_addr = a0; r0_req_wdata = d0;
    r1_req_valid = v1; r1_req_write = w1; r1_req_addr = a1; r1_req_wdata = d1;
  endtask

  // Drive one cycle's requests, then return just after the model has checked it.
  task automatic step(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    drive(v0, w0, a0, d0, v1, w1, a1, d1);
    #3;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i * 7);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
    end
    mem_read_data = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);

    // first grant in the first cycle out of reset
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 0, 32'd3, 0, 0, 0, 0, 0);
    #3;
    chk("first_grant_ready", 32'(r0_req_ready), 32'd1);
    idle();
    chk("first_load_data", r0_resp_data, 32'h1000_0015);

    // quiet bus
    idle();
    idle();
    idle();
    chk("quiet_should_write", 32'(mem_should_write), 32'd0);
    chk("quiet_mem_addr", mem_addr, 32'd0);
    chk("quiet_resp_valid", 32'({r0_resp_valid, r1_resp_valid}), 32'd0);

    // host store then core load of the same word
    step(0, 0, 0, 0, 1, 1, 32'd5, 32'hDEAD_BEEF);
    chk("st5_should_write", 32'(mem_should_write), 32'd1);
    step(1, 0, 32'd5, 0, 0, 0, 0, 0);
    chk("st5_r1_resp_valid", 32'(r1_resp_valid), 32'd1);
    chk("st5_r1_resp_data", r1_resp_data, 32'd0);
    idle();
    chk("ld5_r0_resp_data", r0_resp_data, 32'hDEAD_BEEF);

    // out-of-range load and store, then the top in-range word
    step(1, 0, 32'h400, 0, 0, 0, 0, 0);
    chk("oor_ld_should_write", 32'(mem_should_write), 32'd0);
    step(0, 0, 0, 0, 1, 1, 32'h405, 32'h1234_5678);
    chk("oor_ld_err", 32'(r0_resp_err), 32'd1);
    chk("oor_ld_data", r0_resp_data, 32'd0);
    chk("oor_st_should_write", 32'(mem_should_write), 32'd0);
    idle();
    chk("oor_st_err", 32'(r1_resp_err), 32'd1);
    chk("oor_mem5_intact", mem[5], 32'hDEAD_BEEF);
    chk("oor_mem0_intact", mem[0], 32'h1000_0000);
    step(1, 1, 32'h3FF, 32'hA5A5_A5A5, 0, 0, 0, 0);
    step(1, 0, 32'h3FF, 0, 0, 0, 0, 0);
    idle();
    chk("top_word_data", r0_resp_data, 32'hA5A5_A5A5);

    // reset lands between acceptance and the response edge
    step(1, 1, 32'd7, 32'hCAFE_F00D, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #4;
    chk("drop_r0_resp_valid", 32'(r0_resp_valid), 32'd0);
    chk("drop_r1_resp_valid", 32'(r1_resp_valid), 32'd0);
    chk("drop_mem7", mem[7], 32'hCAFE_F00D);

    // both requesters valid every cycle from reset: r0 first, then alternate
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 0, 32'd10, 0, 1, 0, 32'd11, 0);
    #3;
    chk("alt_first_r0", 32'(r0_req_ready), 32'd1);
    for (int k = 1; k < 6; k++) begin
      step(1, 0, 32'd10, 0, 1, 0, 32'd11, 0);
      chk("alt_r1_turn", 32'(r1_req_ready), 32'(k % 2));
    end

    // r0 alone for four cycles, then contention goes to r1
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 32'(20 + k), 0, 0, 0, 0, 0);
      chk("solo_r0_ready", 32'(r0_req_ready), 32'd1);
    end
    step(1, 0, 32'd24, 0, 1, 0, 32'd25, 0);
    chk("solo_then_r1", 32'(r1_req_ready), 32'd1);
    step(1, 0, 32'd24, 0, 1, 0, 32'd25, 0);
    chk("solo_then_r0", 32'(r0_req_ready), 32'd1);

    // mixed traffic: r0 stores while r1 reads the word stored just before
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 32'(100 + k), 32'h1111_1111 * 32'(k + 1), 1, 0, 32'(99 + k), 0);
    end
    idle();
    idle();
    chk("mixed_mem103", mem[103], 32'h4444_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
